// File: rtl/out_reg_bank_pkg.sv
// Shared limits and helpers for the output register bank.
package out_reg_bank_pkg;

    localparam int MAX_STAGES = 4;
    localparam int MAX_WIDTH  = 32;

    // Enough bits to count 0..stages inclusive.
    function automatic int fill_cnt_w(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/out_reg_bank_stage.sv
// One WIDTH-bit enabled register with synchronous reset to INIT.
module out_reg_stage #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            data_q <= INIT;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/out_reg_bank.sv
// Pad-side output register bank: STAGES-deep pipeline per channel, per-bit
// combinational bypass, and a fill flag that asserts once the pipe is primed.
module out_reg_bank
    import out_reg_bank_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] BYPASS_MASK = '0,
    parameter logic [WIDTH-1:0] INIT        = '0
) (
    (* clkbuf_sink *)
    input  logic             IQC,
    input  logic             QRT,
    input  logic             IQE,
    input  logic [WIDTH-1:0] OQI,
    output logic [WIDTH-1:0] F2A,
    output logic             F2A_VLD
);

    // Timing arcs for constraints: OQI/IQE/QRT setup+hold to posedge IQC,
    // IQC->F2A clock-to-out (bypassed bits are a pure OQI->F2A path).

    localparam int               CNT_W    = fill_cnt_w(STAGES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STAGES);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("out_reg_bank: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
        end
        if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
            $error("out_reg_bank: STAGES %0d outside 1..%0d", STAGES, MAX_STAGES);
        end
    endgenerate

    logic [WIDTH-1:0] chain [0:STAGES];

    assign chain[0] = OQI;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            out_reg_stage #(
                .WIDTH (WIDTH),
                .INIT  (INIT)
            ) u_stage (
                .clk  (IQC),
                .srst (QRT),
                .en_i (IQE),
                .d_i  (chain[gi]),
                .q_o  (chain[gi+1])
            );
        end

        // Bypass path is nothing but the mux leg straight from OQI.
        for (gi = 0; gi < WIDTH; gi++) begin : g_out_mux
            assign F2A[gi] = BYPASS_MASK[gi] ? OQI[gi] : chain[STAGES][gi];
        end
    endgenerate

    logic [CNT_W-1:0] fill_q, fill_d;
    logic             vld_q, vld_d;

    always_comb begin
        fill_d = fill_q;
        if (IQE && (fill_q != CNT_FULL)) begin
            fill_d = fill_q + CNT_W'(1);
        end
        vld_d = (fill_d == CNT_FULL);
    end

    always_ff @(posedge IQC) begin
        if (QRT) begin
            fill_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            fill_q <= fill_d;
            vld_q  <= vld_d;
        end
    end

    assign F2A_VLD = vld_q;

endmodule

// File: tb/tb_out_reg_bank.sv
// Directed bench for out_reg_bank across several parameterisations.
module tb_out_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: W8 S3 INIT 3C; B: W8 S2; C: W8 S1 bypass 0F; D: W8 S4 INIT 3C; E: W4 S2 all bypass
    logic       a_rst = 1'b1, a_en = 1'b0; logic [7:0] a_d = '0, a_q; logic a_v;
    logic       b_rst = 1'b1, b_en = 1'b0; logic [7:0] b_d = '0, b_q; logic b_v;
    logic       c_rst = 1'b1, c_en = 1'b0; logic [7:0] c_d = '0, c_q; logic c_v;
    logic       d_rst = 1'b1, d_en = 1'b0; logic [7:0] d_d = '0, d_q; logic d_v;
    logic       e_rst = 1'b1, e_en = 1'b0; logic [3:0] e_d = '0, e_q; logic e_v;

    out_reg_bank #(.WIDTH(8), .STAGES(3), .BYPASS_MASK(8'h00), .INIT(8'h3C)) u_a (
        .IQC(clk), .QRT(a_rst), .IQE(a_en), .OQI(a_d), .F2A(a_q), .F2A_VLD(a_v));
    out_reg_bank #(.WIDTH(8), .STAGES(2), .BYPASS_MASK(8'h00), .INIT(8'h00)) u_b (
        .IQC(clk), .QRT(b_rst), .IQE(b_en), .OQI(b_d), .F2A(b_q), .F2A_VLD(b_v));
    out_reg_bank #(.WIDTH(8), .STAGES(1), .BYPASS_MASK(8'h0F), .INIT(8'h00)) u_c (
        .IQC(clk), .QRT(c_rst), .IQE(c_en), .OQI(c_d), .F2A(c_q), .F2A_VLD(c_v));
    out_reg_bank #(.WIDTH(8), .STAGES(4), .BYPASS_MASK(8'h00), .INIT(8'h3C)) u_d (
        .IQC(clk), .QRT(d_rst), .IQE(d_en), .OQI(d_d), .F2A(d_q), .F2A_VLD(d_v));
    out_reg_bank #(.WIDTH(4), .STAGES(2), .BYPASS_MASK(4'hF), .INIT(4'h0)) u_e (
        .IQC(clk), .QRT(e_rst), .IQE(e_en), .OQI(e_d), .F2A(e_q), .F2A_VLD(e_v));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] h0, h1, h2;

    initial begin
        // Everyone in reset for one edge, then release the idle instances.
        tick();
        chk("a_reset_f2a", 32'(a_q), 32'h3C);
        chk("a_reset_vld", 32'(a_v), 32'h0);

        // Scenario 4: reset wins over enable, OQI not captured.
        a_rst = 1'b1; a_en = 1'b1; a_d = 8'hFF;
        tick();
        chk("s4_f2a", 32'(a_q), 32'h3C);
        chk("s4_vld", 32'(a_v), 32'h0);

        // Scenario 1: three-stage fill.
        a_rst = 1'b0;
        a_d = 8'h11; tick(); chk("s1_e1_f2a", 32'(a_q), 32'h3C); chk("s1_e1_vld", 32'(a_v), 32'h0);
        a_d = 8'h22; tick(); chk("s1_e2_f2a", 32'(a_q), 32'h3C); chk("s1_e2_vld", 32'(a_v), 32'h0);
        a_d = 8'h33; tick(); chk("s1_e3_f2a", 32'(a_q), 32'h11); chk("s1_e3_vld", 32'(a_v), 32'h1);
        a_d = 8'h44; tick(); chk("s1_e4_f2a", 32'(a_q), 32'h22); chk("s1_e4_vld", 32'(a_v), 32'h1);

        // Hold with enable low.
        a_en = 1'b0; a_d = 8'hAA;
        tick(); chk("a_hold_f2a", 32'(a_q), 32'h22); chk("a_hold_vld", 32'(a_v), 32'h1);
        tick(); chk("a_hold2_f2a", 32'(a_q), 32'h22);

        // Scenario 6: long run, no wrap; data delayed by exactly three edges.
        a_en = 1'b1;
        h0 = 8'h44; h1 = 8'h33; h2 = 8'h22;
        for (int i = 0; i < 1000; i++) begin
            a_d = 8'(i * 7 + 3);
            tick();
            h2 = h1; h1 = h0; h0 = a_d;
            chk("s6_vld", 32'(a_v), 32'h1);
            chk("s6_f2a", 32'(a_q), 32'(h2));
        end

        // Scenario 2: two stages with enable gaps.
        b_rst = 1'b1; b_en = 1'b1; tick();
        chk("s2_reset_vld", 32'(b_v), 32'h0);
        b_rst = 1'b0;
        b_d = 8'hA5; tick(); chk("s2_e1_f2a", 32'(b_q), 32'h00); chk("s2_e1_vld", 32'(b_v), 32'h0);
        b_en = 1'b0; b_d = 8'h5A;
        tick(); chk("s2_g1_f2a", 32'(b_q), 32'h00); chk("s2_g1_vld", 32'(b_v), 32'h0);
        tick(); chk("s2_g2_f2a", 32'(b_q), 32'h00); chk("s2_g2_vld", 32'(b_v), 32'h0);
        b_en = 1'b1;
        tick(); chk("s2_e2_f2a", 32'(b_q), 32'hA5); chk("s2_e2_vld", 32'(b_v), 32'h1);
        b_d = 8'h00;
        tick(); chk("s2_e3_f2a", 32'(b_q), 32'h5A);

        // Scenario 3: low nibble bypassed, also while in reset.
        c_rst = 1'b1; c_en = 1'b1; c_d = 8'h00; tick();
        chk("s3_reset_f2a", 32'(c_q), 32'h00);
        c_d = 8'hFF; #1;
        chk("s3_byp_in_reset", 32'(c_q), 32'h0F);
        tick();
        chk("s3_reset_vld", 32'(c_v), 32'h0);
        c_rst = 1'b0; c_d = 8'h00;
        tick(); chk("s3_e1_f2a", 32'(c_q), 32'h00); chk("s3_e1_vld", 32'(c_v), 32'h1);
        #3; c_d = 8'hFF; #1;
        chk("s3_mid_f2a", 32'(c_q), 32'h0F);
        tick(); chk("s3_e2_f2a", 32'(c_q), 32'hFF);
        c_d = 8'hA0; #1;
        chk("s3_mid2_f2a", 32'(c_q), 32'hF0);

        // Scenario 5: four stages, reset mid-fill, full refill required.
        d_rst = 1'b1; d_en = 1'b1; tick();
        d_rst = 1'b0;
        d_d = 8'h01; tick();
        d_d = 8'h02; tick();
        chk("s5_mid_vld", 32'(d_v), 32'h0);
        d_rst = 1'b1; d_d = 8'h03; tick();
        chk("s5_rst_f2a", 32'(d_q), 32'h3C); chk("s5_rst_vld", 32'(d_v), 32'h0);
        d_rst = 1'b0;
        d_d = 8'h10; tick(); chk("s5_r1_vld", 32'(d_v), 32'h0); chk("s5_r1_f2a", 32'(d_q), 32'h3C);
        d_d = 8'h20; tick(); chk("s5_r2_vld", 32'(d_v), 32'h0);
        d_d = 8'h30; tick(); chk("s5_r3_vld", 32'(d_v), 32'h0); chk("s5_r3_f2a", 32'(d_q), 32'h3C);
        d_d = 8'h40; tick(); chk("s5_r4_vld", 32'(d_v), 32'h1); chk("s5_r4_f2a", 32'(d_q), 32'h10);

        // All bits bypassed: fill flag still tracks the pipeline.
        e_rst = 1'b1; e_en = 1'b1; e_d = 4'h9; tick();
        chk("e_reset_vld", 32'(e_v), 32'h0); chk("e_reset_f2a", 32'(e_q), 32'h9);
        e_rst = 1'b0;
        e_d = 4'h6; tick(); chk("e_e1_vld", 32'(e_v), 32'h0); chk("e_e1_f2a", 32'(e_q), 32'h6);
        e_d = 4'h3; tick(); chk("e_e2_vld", 32'(e_v), 32'h1); chk("e_e2_f2a", 32'(e_q), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
